uart_data_sender: RTL

Transmit-side counterpart of the 784-element UART image collector. On a start pulse, it reads 784 signed 32-bit elements from an external element store, one address at a time. Each element is reduced to one bit (nonzero -> 1), eight bits are packed per byte, and the resulting 98 bytes go out over an 8N1 UART TX line. It is used to echo the binarised image, or a result buffer, back to the host.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_tx.sv | 137 +++++++++++++
 rtl/uart_data_sender.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and encodings for the UART image path.
// Holds the default bit period, the image geometry (784 elements packed
// into 98 bytes), the sender and TX frame state encodings, and the helper
// that forms an element address from a byte index and a bit position.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 5209;
  localparam int NUM_ELEMENTS         = 784;
  localparam int BYTES_PER_IMAGE      = NUM_ELEMENTS / 8;

  // Sender (fetch/pack) state encodings
  localparam logic [2:0] SND_IDLE_ENC    = 3'd0;
  localparam logic [2:0] SND_FETCH_ENC   = 3'd1;
  localparam logic [2:0] SND_LOAD_ENC    = 3'd2;
  localparam logic [2:0] SND_WAIT_TX_ENC = 3'd3;
  localparam logic [2:0] SND_DONE_ENC    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = SND_IDLE_ENC,
    ST_FETCH   = SND_FETCH_ENC,
    ST_LOAD    = SND_LOAD_ENC,
    ST_WAIT_TX = SND_WAIT_TX_ENC,
    ST_DONE    = SND_DONE_ENC
  } send_state_t;

  // UART TX frame state encodings
  localparam logic [2:0] TXS_IDLE_ENC    = 3'd0;
  localparam logic [2:0] TXS_START_ENC   = 3'd1;
  localparam logic [2:0] TXS_DATA_ENC    = 3'd2;
  localparam logic [2:0] TXS_STOP_ENC    = 3'd3;
  localparam logic [2:0] TXS_CLEANUP_ENC = 3'd4;

  typedef enum logic [2:0] {
    TX_IDLE      = TXS_IDLE_ENC,
    TX_START_BIT = TXS_START_ENC,
    TX_DATA_BITS = TXS_DATA_ENC,
    TX_STOP_BIT  = TXS_STOP_ENC,
    TX_CLEANUP   = TXS_CLEANUP_ENC
  } tx_state_t;

  // byte_idx*8 + k: with k < 8 this is a plain concatenation, so it can
  // never carry into the byte index and the largest value is 783.
  function automatic logic [9:0] elem_addr(input logic [6:0] byte_idx,
                                           input logic [2:0] k);
    return {byte_idx, k};
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter.
// Ports:
//   i_Clock      system clock (rising edge)
//   i_Rst_L      asynchronous active-low reset; line goes high at once
//   i_TX_DV      one-cycle strobe: latch i_TX_Byte and start a frame
//   i_TX_Byte    byte to send, LSB first
//   o_TX_Active  high from the first start-bit cycle to the last stop-bit cycle
//   o_TX_Serial  UART line, idles high
//   o_TX_Done    one-cycle pulse during the last stop-bit cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Done is registered, so it is raised one count early to land on the
  // final stop-bit cycle; this keeps the sender's inter-byte gap exact.
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);

  tx_state_t        state, state_next;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       data, data_next;
  logic             serial, serial_next;
  logic             active, active_next;
  logic             done, done_next;

  assign o_TX_Serial = serial;
  assign o_TX_Active = active;
  assign o_TX_Done   = done;

  // Frame state and registered line outputs
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= TX_IDLE;
      clk_cnt <= '0;
      bit_idx <= 3'd0;
      data    <= 8'd0;
      serial  <= 1'b1;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_idx <= bit_idx_next;
      data    <= data_next;
      serial  <= serial_next;
      active  <= active_next;
      done    <= done_next;
    end
  end

  // Frame sequencing: start bit, 8 data bits (data[0] is always on the line), stop bit
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    data_next    = data;
    serial_next  = serial;
    active_next  = active;
    done_next    = 1'b0;

    case (state)
      TX_IDLE: begin
        serial_next  = 1'b1;
        clk_cnt_next = '0;
        bit_idx_next = 3'd0;
        if (i_TX_DV) begin
          data_next   = i_TX_Byte;
          serial_next = 1'b0;
          active_next = 1'b1;
          state_next  = TX_START_BIT;
        end else begin
          active_next = 1'b0;
        end
      end

      TX_START_BIT: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          serial_next  = data[0];
          state_next   = TX_DATA_BITS;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end

      TX_DATA_BITS: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            serial_next = 1'b1;
            state_next  = TX_STOP_BIT;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            data_next    = {1'b0, data[7:1]};
            serial_next  = data[1];
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end

      TX_STOP_BIT: begin
        done_next = (clk_cnt == CNT_DONE);
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          active_next  = 1'b0;
          state_next   = TX_CLEANUP;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end

      TX_CLEANUP: begin
        state_next = TX_IDLE;
      end

      default: begin
        state_next  = TX_IDLE;
        serial_next = 1'b1;
        active_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_data_sender.sv
// Reads NUM_ELEMENTS signed 32-bit elements from a synchronous-read store,
// reduces each to one bit (nonzero -> 1), packs 8 bits per byte (lowest
// address in bit 0) and sends the bytes over an 8N1 UART line.
// Ports:
//   i_Clock       system clock (rising edge)
//   i_Rst_L       asynchronous active-low reset; aborts any transfer
//   i_Start       one-cycle start pulse, honoured only when idle
//   i_Elem_Data   element at the previous cycle's o_Elem_Addr
//   o_Elem_Addr   element address being read
//   o_Busy        high from the cycle after an accepted start until DONE exits
//   o_Done        one-cycle pulse once the last stop bit has completed
//   o_Byte_Count  bytes fully sent in the current transfer
//   o_TX_Active   high while a frame is on the line
//   o_TX_Serial   UART line, idles high
module uart_data_sender
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int NUM_ELEMENTS = uart_pkg::NUM_ELEMENTS  // multiple of 8
) (
  input  logic               i_Clock,
  input  logic               i_Rst_L,
  input  logic               i_Start,
  input  logic signed [31:0] i_Elem_Data,
  output logic        [9:0]  o_Elem_Addr,
  output logic               o_Busy,
  output logic               o_Done,
  output logic        [6:0]  o_Byte_Count,
  output logic               o_TX_Active,
  output logic               o_TX_Serial
);

  localparam int BYTES_TO_SEND = NUM_ELEMENTS / 8;
  localparam logic [6:0] LAST_BYTE = 7'(BYTES_TO_SEND - 1);

  send_state_t state, state_next;
  logic [6:0]  byte_idx, byte_idx_next;
  logic [3:0]  k, k_next;  // FETCH cycle, 0..8
  logic [7:0]  shift, shift_next;
  logic [9:0]  addr, addr_next;
  logic        busy, busy_next;
  logic        done, done_next;
  logic [6:0]  byte_count, byte_count_next;
  logic        tx_dv, tx_dv_next;
  logic        tx_done;
  logic        elem_nz;

  assign elem_nz      = |i_Elem_Data;
  assign o_Elem_Addr  = addr;
  assign o_Busy       = busy;
  assign o_Done       = done;
  assign o_Byte_Count = byte_count;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_Clock    (i_Clock),
    .i_Rst_L    (i_Rst_L),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (shift),
    .o_TX_Active(o_TX_Active),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Done  (tx_done)
  );

  // Sender state, counters and registered outputs
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= ST_IDLE;
      byte_idx   <= 7'd0;
      k          <= 4'd0;
      shift      <= 8'd0;
      addr       <= 10'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_count <= 7'd0;
      tx_dv      <= 1'b0;
    end else begin
      state      <= state_next;
      byte_idx   <= byte_idx_next;
      k          <= k_next;
      shift      <= shift_next;
      addr       <= addr_next;
      busy       <= busy_next;
      done       <= done_next;
      byte_count <= byte_count_next;
      tx_dv      <= tx_dv_next;
    end
  end

  // Fetch/pack sequencing; every output is computed one cycle ahead
  always_comb begin
    state_next      = state;
    byte_idx_next   = byte_idx;
    k_next          = k;
    shift_next      = shift;
    addr_next       = addr;
    busy_next       = busy;
    done_next       = 1'b0;
    byte_count_next = byte_count;
    tx_dv_next      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_Start) begin
          state_next      = ST_FETCH;
          byte_idx_next   = 7'd0;
          k_next          = 4'd0;
          addr_next       = elem_addr(7'd0, 3'd0);
          busy_next       = 1'b1;
          byte_count_next = 7'd0;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // Data lags the address by one cycle, so cycle k carries element
        // k-1; shifting in at the MSB leaves the first element in bit 0.
        if (k != 4'd0) begin
          shift_next = {elem_nz, shift[7:1]};
        end else begin
          shift_next = shift;
        end
        if (k < 4'd7) begin
          addr_next = elem_addr(byte_idx, k[2:0] + 3'd1);
        end else begin
          addr_next = addr;
        end
        if (k == 4'd8) begin
          k_next     = 4'd0;
          tx_dv_next = 1'b1;  // strobe is high during LOAD
          state_next = ST_LOAD;
        end else begin
          k_next = k + 4'd1;
        end
      end

      ST_LOAD: begin
        state_next = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        if (tx_done) begin
          byte_count_next = byte_count + 7'd1;
          if (byte_idx == LAST_BYTE) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            byte_idx_next = byte_idx + 7'd1;
            k_next        = 4'd0;
            addr_next     = elem_addr(byte_idx + 7'd1, 3'd0);
            state_next    = ST_FETCH;
          end
        end else begin
          state_next = ST_WAIT_TX;
        end
      end

      ST_DONE: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
